fifo_rd_ser: RTL and testbench
==============================

# fifo_rd_ser

Drain-side companion to the team's `fifo` block. It pops words from a FIFO's read port (`dout`/`dout_val`/`pop`) and serializes each WIDTH-bit word into OUT_W-bit beats on a valid/ready stream, most significant beat first. It sits between a buffering FIFO and a narrow link or datapath, and applies downstream backpressure without losing data.

## Interface
- `WIDTH`, default 8: FIFO word width; must be an integer multiple of OUT_W.
- `OUT_W`, default 2: serial beat width. NB = WIDTH/OUT_W beats per word, with NB ≥ 2.
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `fif_dout`  input  WIDTH: FIFO head word. It is combinational from the FIFO and valid when `fif_dout_val` is high.
- `fif_dout_val`  input  1: FIFO is non-empty.
- `fif_pop`  output  1: pops the FIFO head at this clock edge.
- `ser_dat`  output  OUT_W: current beat.
- `ser_val`  output  1: beat valid.
- `ser_rdy`  input  1: downstream accepts the beat.
- `ser_last`  output  1: the current beat is the final beat of its word.
- `busy`  output  1: a word is in progress, i.e. the block is not in IDLE.

## Operation
- **State machine:** IDLE, SHIFT, and PAR. PAR exists only with the parity feature.
- **Load condition:** `load = fif_dout_val & (IDLE | final_hs)`.
  - `fif_pop = load & !rst`. This signal is combinational.
  - `final_hs` is the handshake (`ser_val & ser_rdy`) on the final beat of the current word.
- **On load:**
  - The shift register captures `fif_dout`.
  - The beat counter is set to 0.
  - The state becomes SHIFT.
- **In SHIFT:**
  - `ser_val = 1`.
  - `ser_dat` = shift register bits [WIDTH-1 -: OUT_W].
  - `ser_last = (cnt == NB-1)`.
- **On a handshake in SHIFT that is not the final beat:**
  - The shift register shifts left by OUT_W, with zero fill.
  - The counter increments.
- **Final beat:** the handshake at `cnt == NB-1`.
  - If `load` is true, the next word is reloaded with no bubble.
  - Otherwise the state goes to IDLE, and the shift register and counter hold.
- **Counter:** width is $clog2(NB) bits, minimum 1. It never exceeds NB-1, so there is no wrap-around.
- **No handshake:** while `ser_val & !ser_rdy`, the state, `ser_dat`, and `ser_last` hold stable.
- **IDLE outputs:** `ser_val = 0`, `ser_last = 0`, `busy = 0`, and `ser_dat = 0`.
- **Empty FIFO:** if `fif_dout_val = 0` in IDLE, the block stays in IDLE and never pops.
- **Reset:** every register is cleared asynchronously.
  - Cleared registers: state = IDLE, shift register = 0, counter = 0, parity = 0.
  - Resulting outputs: `ser_val = 0`, `ser_dat = 0`, `ser_last = 0`, `busy = 0`.
  - `fif_pop` is forced to 0 while `rst` is high.
  - If reset asserts mid-word, the partially sent word is discarded. It was already popped and is not re-sent.

## Timing
- **Load latency:** when `fif_dout_val` is high in IDLE at cycle N, `fif_pop` is high in cycle N and the first beat is valid in cycle N+1.
- **Throughput:** with `ser_rdy` held high and the FIFO non-empty, the block produces one beat per cycle with no gaps between words.
  - Without the parity feature, NB cycles per word.
  - With the parity feature, NB+1 cycles per word.
- **Pop rate:** `fif_pop` pulses at most once per word, in the same cycle as the final-beat handshake or the IDLE load.
- **Backpressure:** `ser_rdy` may toggle arbitrarily. Beats are transferred only on cycles where `ser_val & ser_rdy` is high.

## Configuration
- **Macro:** `FIFO_RD_SER_PARITY_EN`.
- **When defined:**
  - The data beat at `cnt == NB-1` is no longer final: it has `ser_last = 0`, and its handshake moves the state to PAR.
  - PAR drives one extra beat with `ser_dat = {(OUT_W-1)'b0, ^word}`, the even-parity bit of the loaded word, and `ser_last = 1`.
  - The PAR handshake is `final_hs`.
  - The parity register is computed at load time.
- **When undefined:** there is no PAR state and no parity register. The final data beat carries `ser_last`.

## Test plan
Unless stated otherwise, scenarios use WIDTH=8, OUT_W=2, and no parity.

- **Single word:** one word 0xB4 with `ser_rdy` = 1 → beats 2, 3, 1, 0 in four consecutive cycles; `ser_last` high on the 4th beat only; a single `fif_pop` pulse; then IDLE with `busy` = 0.
- **Back-to-back words:** 0xB4 then 0x1E preloaded, `ser_rdy` = 1 → 8 consecutive beats 2, 3, 1, 0, 0, 1, 3, 2; no gap; `fif_pop` high in the load cycle and in the 4th-beat cycle.
- **Backpressure:** `ser_rdy` = 0 for 3 cycles while the 2nd beat of 0xB4 is presented → `ser_dat` = 3 held for 3 cycles, no extra pop, and the remaining beats are correct.
- **Empty FIFO:** `fif_dout_val` = 0 for 20 cycles → `fif_pop`, `ser_val`, and `busy` remain 0.
- **Mid-word reset:** `rst` asserted after the 2nd beat of 0xB4 and released with `fif_dout_val` = 0 → all outputs are 0 immediately and stay in IDLE; `fif_pop` is 0 during reset.
- **Parity (macro defined):** 0xB4 → 5th beat is 0 with `ser_last`. 0xB5 → 5th beat is 1 with `ser_last`. `ser_last` is low on the 4th beat.

Source files
------------

// File: rtl/fifo_rd_ser_if.sv
// Handshake bundle for fifo_rd_ser: FIFO read port on one side, valid/ready beat stream on the other.
// master = the serializer itself, slave = the FIFO plus downstream sink seen from outside.
interface fifo_rd_ser_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2
);
  logic [WIDTH-1:0] fif_dout;
  logic             fif_dout_val;
  logic             fif_pop;
  logic [OUT_W-1:0] ser_dat;
  logic             ser_val;
  logic             ser_rdy;
  logic             ser_last;
  logic             busy;

  modport master (
    input  fif_dout, fif_dout_val, ser_rdy,
    output fif_pop, ser_dat, ser_val, ser_last, busy
  );

  modport slave (
    output fif_dout, fif_dout_val, ser_rdy,
    input  fif_pop, ser_dat, ser_val, ser_last, busy
  );
endinterface

// File: rtl/fifo_rd_ser.sv
// Pops FIFO words and serializes them MSB-beat first onto a valid/ready stream.
// Optional trailing even-parity beat: define FIFO_RD_SER_PARITY_EN.
module fifo_rd_ser #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_ser_if.master bus
);
  localparam int NB = WIDTH / OUT_W;
  localparam int CW = (NB > 2) ? $clog2(NB) : 1;

`ifdef FIFO_RD_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             last_data;
  logic             final_hs;
  logic             load;
`ifdef FIFO_RD_SER_PARITY_EN
  logic             par, par_n;
`endif

  assign last_data = (cnt == CW'(NB - 1));

`ifdef FIFO_RD_SER_PARITY_EN
  assign final_hs = (state == PAR) & bus.ser_rdy;
`else
  assign final_hs = (state == SHIFT) & last_data & bus.ser_rdy;
`endif

  // Reload straight off the final handshake so consecutive words leave no bubble.
  assign load        = bus.fif_dout_val & ((state == IDLE) | final_hs);
  assign bus.fif_pop = load & ~rst;

  // NOTE: every variable gets its hold value first, so no path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
`ifdef FIFO_RD_SER_PARITY_EN
    par_n   = par;
`endif
    if (load) begin
      state_n = SHIFT;
      sh_n    = bus.fif_dout;
      cnt_n   = '0;
`ifdef FIFO_RD_SER_PARITY_EN
      par_n   = ^bus.fif_dout;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (bus.ser_rdy) begin
            if (last_data) begin
`ifdef FIFO_RD_SER_PARITY_EN
              state_n = PAR;
`else
              state_n = IDLE;
`endif
            end else begin
              sh_n  = sh << OUT_W;
              cnt_n = cnt + CW'(1);
            end
          end
        end
`ifdef FIFO_RD_SER_PARITY_EN
        PAR: begin
          if (bus.ser_rdy) state_n = IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
`ifdef FIFO_RD_SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
`ifdef FIFO_RD_SER_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  always_comb begin
    bus.ser_val  = (state != IDLE);
    bus.busy     = (state != IDLE);
    bus.ser_dat  = '0;
    bus.ser_last = 1'b0;
    case (state)
      SHIFT: begin
        bus.ser_dat = sh[WIDTH-1 -: OUT_W];
`ifndef FIFO_RD_SER_PARITY_EN
        bus.ser_last = last_data;
`endif
      end
`ifdef FIFO_RD_SER_PARITY_EN
      PAR: begin
        bus.ser_dat  = OUT_W'(par);
        bus.ser_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fifo_rd_ser.sv
// Directed bench for fifo_rd_ser (WIDTH=8, OUT_W=2) with a small queue standing in for the FIFO.
// Parity scenarios are selected when FIFO_RD_SER_PARITY_EN is defined.
module tb_fifo_rd_ser;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  fifo_rd_ser_if #(.WIDTH(8), .OUT_W(2)) bus ();
  fifo_rd_ser #(.WIDTH(8), .OUT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fif_dout_val = (q.size() > 0);
    bus.fif_dout     = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    drive_fifo();
    #1;
  endtask

  // Advance one clock from one negedge to the next, retiring the head if it was popped.
  task automatic cyc();
    logic pop_s;
    pop_s = bus.fif_pop;
    @(posedge clk);
    if (pop_s) begin
      void'(q.pop_front());
      pops++;
    end
    #1;
    drive_fifo();
    @(negedge clk);
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] dat, input logic last, input logic pop);
    chk({tag, ".val"},  bus.ser_val, 1'b1);
    chk({tag, ".dat"},  bus.ser_dat, dat);
    chk({tag, ".last"}, bus.ser_last, last);
    chk({tag, ".pop"},  bus.fif_pop, pop);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".val"},  bus.ser_val, 1'b0);
    chk({tag, ".busy"}, bus.busy, 1'b0);
    chk({tag, ".dat"},  bus.ser_dat, 2'd0);
    chk({tag, ".last"}, bus.ser_last, 1'b0);
  endtask

  initial begin
    int p0;
    logic [1:0] exp_dat[8];
    logic       exp_last[8];
    logic       exp_pop[8];

    rst = 1'b1;
    bus.ser_rdy = 1'b0;
    drive_fifo();
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset.pop", bus.fif_pop, 1'b0);
    push(8'hB4);
    chk("reset_pop_forced", bus.fif_pop, 1'b0);
    q.delete();
    drive_fifo();
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Empty FIFO: nothing happens for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      chk("empty.pop",  bus.fif_pop, 1'b0);
      chk("empty.val",  bus.ser_val, 1'b0);
      chk("empty.busy", bus.busy, 1'b0);
      cyc();
    end

    bus.ser_rdy = 1'b1;

`ifndef FIFO_RD_SER_PARITY_EN
    // Single word 0xB4 -> 2,3,1,0.
    p0 = pops;
    push(8'hB4);
    chk("single.load_pop", bus.fif_pop, 1'b1);
    cyc(); chk_beat("single.b0", 2'd2, 1'b0, 1'b0);
    cyc(); chk_beat("single.b1", 2'd3, 1'b0, 1'b0);
    cyc(); chk_beat("single.b2", 2'd1, 1'b0, 1'b0);
    cyc(); chk_beat("single.b3", 2'd0, 1'b1, 1'b0);
    cyc(); chk_idle("single.after");
    chk("single.pops", pops - p0, 1);

    // Back-to-back 0xB4, 0x1E with no gap.
    exp_dat  = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_pop  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    p0 = pops;
    q.push_back(8'hB4);
    push(8'h1E);
    chk("b2b.load_pop", bus.fif_pop, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_beat($sformatf("b2b.b%0d", i), exp_dat[i], exp_last[i], exp_pop[i]);
    end
    cyc(); chk_idle("b2b.after");
    chk("b2b.pops", pops - p0, 2);

    // Backpressure on the 2nd beat of 0xB4 for 3 cycles.
    p0 = pops;
    push(8'hB4);
    chk("bp.load_pop", bus.fif_pop, 1'b1);
    cyc(); chk_beat("bp.b0", 2'd2, 1'b0, 1'b0);
    cyc();
    bus.ser_rdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("bp.hold%0d", i), 2'd3, 1'b0, 1'b0);
      if (i < 2) cyc();
    end
    bus.ser_rdy = 1'b1;
    #1;
    cyc(); chk_beat("bp.b2", 2'd1, 1'b0, 1'b0);
    cyc(); chk_beat("bp.b3", 2'd0, 1'b1, 1'b0);
    cyc(); chk_idle("bp.after");
    chk("bp.pops", pops - p0, 1);
`else
    // Parity: 0xB4 then 0xB5 back-to-back, each followed by its parity beat.
    exp_dat  = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_pop  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    p0 = pops;
    q.push_back(8'hB4);
    push(8'hB5);
    chk("par.load_pop", bus.fif_pop, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_beat($sformatf("par.b%0d", i), exp_dat[i], exp_last[i], exp_pop[i]);
    end
    cyc(); chk_beat("par.b8", 2'd1, 1'b0, 1'b0);
    cyc(); chk_beat("par.b9", 2'd1, 1'b1, 1'b0);
    cyc(); chk_idle("par.after");
    chk("par.pops", pops - p0, 2);
`endif

    // Mid-word reset after two beats of 0xB4 have transferred.
    push(8'hB4);
    chk("rst_mid.load_pop", bus.fif_pop, 1'b1);
    cyc(); chk_beat("rst_mid.b0", 2'd2, 1'b0, 1'b0);
    cyc(); chk_beat("rst_mid.b1", 2'd3, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    #1;
    chk_idle("rst_mid.in_reset");
    chk("rst_mid.pop", bus.fif_pop, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_idle($sformatf("rst_mid.after%0d", i));
      chk("rst_mid.after_pop", bus.fif_pop, 1'b0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
